// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requester front-ends and the arbiter.
// master: requester side (drives req_i); slave: arbiter side (drives grants).
interface round_robin_arbiter_if #(
    parameter int REQ_NUM = 4,
    parameter int IDX_W   = $clog2(REQ_NUM)
);
    logic [REQ_NUM-1:0] req_i;
    logic [REQ_NUM-1:0] gnt_o;
    logic               gnt_val_o;
    logic [IDX_W-1:0]   gnt_idx_o;

    modport master (
        output req_i,
        input  gnt_o,
        input  gnt_val_o,
        input  gnt_idx_o
    );

    modport slave (
        input  req_i,
        output gnt_o,
        output gnt_val_o,
        output gnt_idx_o
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with bounded tenure and registered one-hot grant.
// Ports: clk_i, rst_n_i (async active-low), bus (slave: req_i in, gnt_o/gnt_val_o/gnt_idx_o out).
module round_robin_arbiter #(
    parameter int REQ_NUM  = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDX_W    = $clog2(REQ_NUM)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    round_robin_arbiter_if.slave        bus
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REQ_NUM-1:0] gnt_q, gnt_d;
    logic               val_q, val_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   arb_base;
    logic [IDX_W:0]     win;
    logic               win_vld;
    logic [IDX_W-1:0]   win_idx;
    logic               tenure_end;

    // Rotated priority encode: first set bit scanning base, base+1, ... with wrap.
    function automatic logic [IDX_W:0] pick(
        input logic [REQ_NUM-1:0] req,
        input logic [IDX_W-1:0]   base
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        int               j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            j = int'(base) + i;
            if (j >= REQ_NUM) j = j - REQ_NUM;
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        if (idx_q == IDX_W'(REQ_NUM - 1)) ptr_nxt = '0;
        else                              ptr_nxt = idx_q + IDX_W'(1);
    end

    // In GRANT the arbitration only matters at tenure end, where the
    // pointer has already moved past the current owner.
    assign arb_base = (state_q == GRANT) ? ptr_nxt : ptr_q;
    assign win      = pick(bus.req_i, arb_base);
    assign win_vld  = win[IDX_W];
    assign win_idx  = win[IDX_W-1:0];

    assign tenure_end = !bus.req_i[idx_q] ||
                        (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        val_d   = val_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = REQ_NUM'(1) << win_idx;
                    val_d   = 1'b1;
                    idx_d   = win_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!tenure_end) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    ptr_d = ptr_nxt;
                    if (win_vld) begin
                        gnt_d = REQ_NUM'(1) << win_idx;
                        val_d = 1'b1;
                        idx_d = win_idx;
                        cnt_d = '0;
                    end else begin
                        gnt_d   = '0;
                        val_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            val_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            val_q   <= val_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.gnt_val_o = val_q;
    assign bus.gnt_idx_o = idx_q;

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Fair round-robin arbiter that shares one downstream resource among `REQ_NUM` requesters. It uses the team's rotating priority-encode scheme to pick the next owner and holds the grant for a bounded tenure. Output is a registered one-hot grant plus its binary index, ready to drive a datapath mux select. It sits between requester front-ends and any single-ported shared block (memory port, bus master, encoder stage).

## Interface
- `REQ_NUM`, default 4: number of requesters; integer ≥ 2.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per tenure; integer ≥ 1.
- `IDX_W`, default `$clog2(REQ_NUM)`: derived; not to be overridden.

Ports:
- `clk_i` input 1: single clock; all state updates on the rising edge.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `req_i` input `REQ_NUM`: request per requester; level-sensitive.
- `gnt_o` output `REQ_NUM`: registered one-hot grant; all-zero when idle.
- `gnt_val_o` output 1: high when any bit of `gnt_o` is set.
- `gnt_idx_o` output `IDX_W`: binary index of the granted requester; holds its last value while idle.

## Operation
- **State:**
  - FSM `IDLE`/`GRANT`.
  - Pointer `ptr` (IDX_W bits) holds the highest-priority index for the next arbitration.
  - Tenure counter `cnt` has width `$clog2(MAX_HOLD+1)`.
- **Arbitration function:** the winner is the first set bit of `req_i` scanning `ptr`, `ptr+1`, … `REQ_NUM-1`, 0, … `ptr-1`, with modulo-`REQ_NUM` wrap. This is a rotated lowest-index priority encode.
- **IDLE:**
  - If `req_i` is nonzero: at the next edge, grant the winner, set `gnt_idx_o` to the winner, clear `cnt` to 0, and go to GRANT.
  - Otherwise remain in IDLE.
- **GRANT** (owner `k = gnt_idx_o`):
  - The tenure ends at an edge where `req_i[k]==0` or `cnt==MAX_HOLD-1`.
  - If the tenure does not end, `cnt` increments and the grant is unchanged.
  - At a tenure end:
    - `ptr <= (k+1) mod REQ_NUM`.
    - The winner is computed from the current `req_i` using the new pointer value.
    - If a winner exists, grant it with `cnt <= 0` and stay in GRANT. There is no idle bubble.
    - If no winner exists, clear `gnt_o`/`gnt_val_o` and go to IDLE.
- **Preemption:** an owner still requesting at expiry competes at lowest priority. If it is the only requester, it is re-granted immediately with a new tenure, and `gnt_o` shows no gap.
- **Pointer updates:** `ptr` changes only at tenure end.
- **Reset** (asynchronous, immediate on `rst_n_i` low, including mid-tenure):
  - Outputs: `gnt_o=0`, `gnt_val_o=0`, `gnt_idx_o=0`.
  - Internal state: `ptr=0`, `cnt=0`, FSM in IDLE.

## Timing
- Request-to-grant latency is 1 cycle from IDLE. A `req_i` seen at edge N gives `gnt_o` valid after edge N.
- Release latency is 1 cycle. The owner sees `gnt_o` asserted for the cycle in which it dropped `req_i`, and requesters must tolerate this trailing grant cycle.
- Handoff is back-to-back. The new grant appears in the cycle after the old owner's last grant cycle.
- With `MAX_HOLD=1`, every tenure lasts 1 cycle, so with all requesting the grant rotates every cycle.
- Worst-case wait for a continuous requester is `(REQ_NUM-1)*MAX_HOLD` cycles after the current tenure ends.
- All outputs are registered; there is no combinational path from `req_i` to the outputs.
- Glitch-free `gnt_o`: exactly zero or one bit set in every cycle.

## Test plan
- **Reset:** hold `rst_n_i=0` with `req_i=1111` → all outputs 0. Release; the first edge → `gnt_o=0001`, `gnt_idx_o=0`, `gnt_val_o=1`.
- **Single requester:** `req_i=0100` for 3 cycles, then `0000` → `gnt_o=0100` from 1 cycle after request, for 3 cycles, then `0000` and `gnt_val_o=0`. The next request `1111` → `gnt_o=1000` (`ptr=3`).
- **Fairness** (`MAX_HOLD=8`, `req_i=1111` constant) → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly 8 cycles each and no gaps.
- **Lone-owner preemption** (`MAX_HOLD=4`, `req_i=0010` constant) → `gnt_o=0010` continuously, `gnt_idx_o=1`, `cnt` wrapping 0→3→0, and `gnt_val_o` never low.
- **Handoff with wrap:** `req_i=1001` from IDLE (`ptr=0`) → `0001` granted; drop bit 0 after 2 grant cycles → the next cycle `gnt_o=1000`. Then drop bit 3 with `req_i=0001` → the next cycle `gnt_o=0001` (`ptr` wrapped to 0).
- **Async reset mid-tenure:** assert `rst_n_i=0` between edges while `gnt_o=0100` → outputs 0 immediately, without waiting for a clock edge. After release with `req_i=0110` → `gnt_o=0010`, confirming `ptr` was reset to 0.
